// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline types: control word, ALU op encodings, NOP constant.
// Stateless package.
// No flow control.
package mips_pipe_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_RTYPE = 3'b010,
        ALU_AND   = 3'b011,
        ALU_OR    = 3'b100,
        ALU_SLT   = 3'b101,
        ALU_LUI   = 3'b110,
        ALU_XOR   = 3'b111
    } alu_op_e;

    // Field order matches the Reg_Dst ... ALU_OP port order.
    typedef struct packed {
        logic                reg_dst;
        logic                alu_src;
        logic                mem_to_reg;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                branch;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    localparam int         CTRL_W   = $bits(ctrl_t);
    localparam ctrl_t      CTRL_NOP = '0;
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_hazard_detect.sv
// Load-use hazard detector between the E-stage load and the decode instruction.
// Latency: purely combinational.
// Backpressure: stall is suppressed while E is held or flushed.
module id_ex_hazard_detect
    import mips_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  valid_e,
    input  logic                  mem_read_e,
    input  logic [REG_ADDR_W-1:0] rt_e,
    input  logic [REG_ADDR_W-1:0] rs_d,
    input  logic [REG_ADDR_W-1:0] rt_d,
    input  logic                  reg_dst_d,
    input  logic                  mem_write_d,
    input  logic                  branch_d,
    input  logic                  hold_e,
    input  logic                  flush_e,
    output logic                  lw_hazard,
    output logic                  stall
);

    logic uses_rt;
    logic rt_dep;

    // Only these instruction classes actually read Rt as a source.
    assign uses_rt   = reg_dst_d | mem_write_d | branch_d;
    assign rt_dep    = (rt_e == rs_d) | (uses_rt & (rt_e == rt_d));
    assign lw_hazard = valid_e & mem_read_e & (rt_e != REG_ADDR_W'(REG_ZERO)) & rt_dep;
    assign stall     = lw_hazard & ~hold_e & ~flush_e;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and branch squash.
// Latency: one cycle D to E. Optional Bubble_Count under ID_EX_BUBBLE_COUNT_EN.
// Backpressure: Hold_E freezes E; Stall_F/Stall_D hold upstream on a load-use hazard.
module id_ex_stage
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Reg_Dst_D,
    input  logic                  ALU_Src_D,
    input  logic                  Mem_To_Reg_D,
    input  logic                  Reg_Write_D,
    input  logic                  Mem_Read_D,
    input  logic                  Mem_Write_D,
    input  logic                  Branch_D,
    input  logic [2:0]            ALU_OP_D,
    input  logic [REG_ADDR_W-1:0] Rs_D,
    input  logic [REG_ADDR_W-1:0] Rt_D,
    input  logic [REG_ADDR_W-1:0] Rd_D,
    input  logic [DATA_W-1:0]     Read_Data1_D,
    input  logic [DATA_W-1:0]     Read_Data2_D,
    input  logic [DATA_W-1:0]     Sign_Imm_D,
    input  logic [DATA_W-1:0]     PC_Plus4_D,
    input  logic                  Flush_E,
    input  logic                  Hold_E,
    output logic                  Reg_Dst_E,
    output logic                  ALU_Src_E,
    output logic                  Mem_To_Reg_E,
    output logic                  Reg_Write_E,
    output logic                  Mem_Read_E,
    output logic                  Mem_Write_E,
    output logic                  Branch_E,
    output logic [2:0]            ALU_OP_E,
    output logic [REG_ADDR_W-1:0] Rs_E,
    output logic [REG_ADDR_W-1:0] Rt_E,
    output logic [REG_ADDR_W-1:0] Rd_E,
    output logic [DATA_W-1:0]     Read_Data1_E,
    output logic [DATA_W-1:0]     Read_Data2_E,
    output logic [DATA_W-1:0]     Sign_Imm_E,
    output logic [DATA_W-1:0]     PC_Plus4_E,
    output logic                  Valid_E,
    output logic                  Stall_F,
    output logic                  Stall_D
`ifdef ID_EX_BUBBLE_COUNT_EN
   ,output logic [31:0]           Bubble_Count
`endif
);

    ctrl_t                 ctrl_d;
    ctrl_t                 ctrl_e;
    logic [REG_ADDR_W-1:0] rs_e, rt_e, rd_e;
    logic [DATA_W-1:0]     rd1_e, rd2_e, imm_e, pc4_e;
    logic                  valid_e;
    logic                  lw_hazard;
    logic                  stall;

    assign ctrl_d = '{reg_dst:    Reg_Dst_D,
                      alu_src:    ALU_Src_D,
                      mem_to_reg: Mem_To_Reg_D,
                      reg_write:  Reg_Write_D,
                      mem_read:   Mem_Read_D,
                      mem_write:  Mem_Write_D,
                      branch:     Branch_D,
                      alu_op:     ALU_OP_D};

    id_ex_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .valid_e     (valid_e),
        .mem_read_e  (ctrl_e.mem_read),
        .rt_e        (rt_e),
        .rs_d        (Rs_D),
        .rt_d        (Rt_D),
        .reg_dst_d   (Reg_Dst_D),
        .mem_write_d (Mem_Write_D),
        .branch_d    (Branch_D),
        .hold_e      (Hold_E),
        .flush_e     (Flush_E),
        .lw_hazard   (lw_hazard),
        .stall       (stall)
    );

    // Priority: reset, flush, hold, load-use bubble, capture.
    always_ff @(posedge Clk) begin
        if (Rst || Flush_E) begin
            ctrl_e  <= CTRL_NOP;
            rs_e    <= '0;
            rt_e    <= '0;
            rd_e    <= '0;
            rd1_e   <= '0;
            rd2_e   <= '0;
            imm_e   <= '0;
            pc4_e   <= '0;
            valid_e <= 1'b0;
        end else if (!Hold_E) begin
            if (lw_hazard) begin
                ctrl_e  <= CTRL_NOP;
                rs_e    <= '0;
                rt_e    <= '0;
                rd_e    <= '0;
                rd1_e   <= '0;
                rd2_e   <= '0;
                imm_e   <= '0;
                pc4_e   <= '0;
                valid_e <= 1'b0;
            end else begin
                ctrl_e  <= ctrl_d;
                rs_e    <= Rs_D;
                rt_e    <= Rt_D;
                rd_e    <= Rd_D;
                rd1_e   <= Read_Data1_D;
                rd2_e   <= Read_Data2_D;
                imm_e   <= Sign_Imm_D;
                pc4_e   <= PC_Plus4_D;
                valid_e <= 1'b1;
            end
        end
    end

`ifdef ID_EX_BUBBLE_COUNT_EN
    // stall is exactly "bubble inserted this edge" once reset is excluded.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Bubble_Count <= '0;
        end else if (stall && (Bubble_Count != 32'hFFFF_FFFF)) begin
            Bubble_Count <= Bubble_Count + 32'd1;
        end
    end
`endif

    assign Reg_Dst_E    = ctrl_e.reg_dst;
    assign ALU_Src_E    = ctrl_e.alu_src;
    assign Mem_To_Reg_E = ctrl_e.mem_to_reg;
    assign Reg_Write_E  = ctrl_e.reg_write;
    assign Mem_Read_E   = ctrl_e.mem_read;
    assign Mem_Write_E  = ctrl_e.mem_write;
    assign Branch_E     = ctrl_e.branch;
    assign ALU_OP_E     = ctrl_e.alu_op;
    assign Rs_E         = rs_e;
    assign Rt_E         = rt_e;
    assign Rd_E         = rd_e;
    assign Read_Data1_E = rd1_e;
    assign Read_Data2_E = rd2_e;
    assign Sign_Imm_E   = imm_e;
    assign PC_Plus4_E   = pc4_e;
    assign Valid_E      = valid_e;
    assign Stall_F      = stall;
    assign Stall_D      = stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a transaction-level model.
module tb_id_ex_stage;
    import mips_pipe_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst, Flush_E, Hold_E;
    ctrl_t       d_ctrl;
    logic [4:0]  Rs_D, Rt_D, Rd_D;
    logic [31:0] Read_Data1_D, Read_Data2_D, Sign_Imm_D, PC_Plus4_D;

    logic        Reg_Dst_E, ALU_Src_E, Mem_To_Reg_E, Reg_Write_E;
    logic        Mem_Read_E, Mem_Write_E, Branch_E, Valid_E, Stall_F, Stall_D;
    logic [2:0]  ALU_OP_E;
    logic [4:0]  Rs_E, Rt_E, Rd_E;
    logic [31:0] Read_Data1_E, Read_Data2_E, Sign_Imm_E, PC_Plus4_E;
`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [31:0] Bubble_Count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    id_ex_stage dut (
        .Clk(Clk), .Rst(Rst),
        .Reg_Dst_D(d_ctrl.reg_dst), .ALU_Src_D(d_ctrl.alu_src), .Mem_To_Reg_D(d_ctrl.mem_to_reg),
        .Reg_Write_D(d_ctrl.reg_write), .Mem_Read_D(d_ctrl.mem_read), .Mem_Write_D(d_ctrl.mem_write),
        .Branch_D(d_ctrl.branch), .ALU_OP_D(d_ctrl.alu_op),
        .Rs_D(Rs_D), .Rt_D(Rt_D), .Rd_D(Rd_D),
        .Read_Data1_D(Read_Data1_D), .Read_Data2_D(Read_Data2_D),
        .Sign_Imm_D(Sign_Imm_D), .PC_Plus4_D(PC_Plus4_D),
        .Flush_E(Flush_E), .Hold_E(Hold_E),
        .Reg_Dst_E(Reg_Dst_E), .ALU_Src_E(ALU_Src_E), .Mem_To_Reg_E(Mem_To_Reg_E),
        .Reg_Write_E(Reg_Write_E), .Mem_Read_E(Mem_Read_E), .Mem_Write_E(Mem_Write_E),
        .Branch_E(Branch_E), .ALU_OP_E(ALU_OP_E),
        .Rs_E(Rs_E), .Rt_E(Rt_E), .Rd_E(Rd_E),
        .Read_Data1_E(Read_Data1_E), .Read_Data2_E(Read_Data2_E),
        .Sign_Imm_E(Sign_Imm_E), .PC_Plus4_E(PC_Plus4_E),
        .Valid_E(Valid_E), .Stall_F(Stall_F), .Stall_D(Stall_D)
`ifdef ID_EX_BUBBLE_COUNT_EN
       ,.Bubble_Count(Bubble_Count)
`endif
    );

    logic [153:0] dut_e;
    assign dut_e = {Reg_Dst_E, ALU_Src_E, Mem_To_Reg_E, Reg_Write_E, Mem_Read_E, Mem_Write_E,
                    Branch_E, ALU_OP_E, Rs_E, Rt_E, Rd_E, Read_Data1_E, Read_Data2_E,
                    Sign_Imm_E, PC_Plus4_E, Valid_E};

    // Reference model: the instruction record sitting in E, plus a bubble tally.
    typedef struct packed {
        ctrl_t       c;
        logic [4:0]  rs, rt, rd;
        logic [31:0] d1, d2, imm, pc4;
        logic        valid;
    } instr_t;

    instr_t      m_e;
    logic [31:0] m_bubbles;

    function automatic instr_t cur_d();
        instr_t t;
        t = '{c: d_ctrl, rs: Rs_D, rt: Rt_D, rd: Rd_D, d1: Read_Data1_D, d2: Read_Data2_D,
              imm: Sign_Imm_D, pc4: PC_Plus4_D, valid: 1'b1};
        return t;
    endfunction

    // Decode instruction reads the register the E-stage load is about to write.
    function automatic bit load_use();
        bit reads_rt;
        reads_rt = d_ctrl.reg_dst || d_ctrl.mem_write || d_ctrl.branch;
        return m_e.valid && m_e.c.mem_read && (m_e.rt != 0) &&
               ((m_e.rt == Rs_D) || (reads_rt && (m_e.rt == Rt_D)));
    endfunction

    function automatic bit exp_stall();
        return load_use() && !Hold_E && !Flush_E;
    endfunction

    task automatic tick();
        instr_t      nxt;
        logic [31:0] nb;
        nxt = m_e;
        nb  = m_bubbles;
        if (Rst) begin
            nxt = '0;
            nb  = 0;
        end else if (Flush_E) begin
            nxt = '0;
        end else if (Hold_E) begin
            nxt = m_e;
        end else if (load_use()) begin
            nxt = '0;
            if (nb != 32'hFFFF_FFFF) nb = nb + 1;
        end else begin
            nxt = cur_d();
        end
        @(posedge Clk);
        #1;
        m_e       = nxt;
        m_bubbles = nb;
    endtask

    task automatic present(input ctrl_t c, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        d_ctrl = c; Rs_D = rs; Rt_D = rt; Rd_D = rd;
        Read_Data1_D = $urandom; Read_Data2_D = $urandom;
        Sign_Imm_D = $urandom; PC_Plus4_D = $urandom;
        Rst = 1'b0; Flush_E = 1'b0; Hold_E = 1'b0;
        #1;
    endtask

    localparam ctrl_t C_LW   = '{reg_dst:0, alu_src:1, mem_to_reg:1, reg_write:1, mem_read:1, mem_write:0, branch:0, alu_op:ALU_ADD};
    localparam ctrl_t C_ADD  = '{reg_dst:1, alu_src:0, mem_to_reg:0, reg_write:1, mem_read:0, mem_write:0, branch:0, alu_op:ALU_RTYPE};
    localparam ctrl_t C_SW   = '{reg_dst:0, alu_src:1, mem_to_reg:0, reg_write:0, mem_read:0, mem_write:1, branch:0, alu_op:ALU_ADD};
    localparam ctrl_t C_ADDI = '{reg_dst:0, alu_src:1, mem_to_reg:0, reg_write:1, mem_read:0, mem_write:0, branch:0, alu_op:ALU_ADD};

    task automatic test_reset();
        present(ctrl_t'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
        Rst = 1'b1;
        tick();
        present(ctrl_t'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
        Rst = 1'b1;
        tick();
        checks++;
        if (dut_e !== '0) begin errors++; $display("FAIL reset_e: got %h expected 0", dut_e); end
        checks++;
        if ({Stall_F, Stall_D} !== 2'b00) begin errors++; $display("FAIL reset_stall: got %b expected 00", {Stall_F, Stall_D}); end
`ifdef ID_EX_BUBBLE_COUNT_EN
        checks++;
        if (Bubble_Count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", Bubble_Count); end
`endif
    endtask

    task automatic test_load_use();
        logic [31:0] add_d1;
        present(C_LW, 5'd3, 5'd8, 5'd0);
        tick();
        present(C_ADD, 5'd8, 5'd9, 5'd10);
        add_d1 = Read_Data1_D;
        checks++;
        if ({Stall_F, Stall_D} !== 2'b11) begin errors++; $display("FAIL load_use_stall: got %b expected 11", {Stall_F, Stall_D}); end
        tick();
        checks++;
        if (Valid_E !== 1'b0 || dut_e !== m_e) begin errors++; $display("FAIL load_use_bubble: got %h expected %h", dut_e, m_e); end
        checks++;
        if ({Stall_F, Stall_D} !== 2'b00) begin errors++; $display("FAIL load_use_unstall: got %b expected 00", {Stall_F, Stall_D}); end
        tick();
        checks++;
        if (Valid_E !== 1'b1 || Read_Data1_E !== add_d1 || dut_e !== m_e) begin
            errors++; $display("FAIL load_use_add: got %h expected %h rd1 %h", dut_e, m_e, add_d1);
        end
    endtask

    task automatic test_store_and_addi();
        present(C_LW, 5'd1, 5'd8, 5'd0);
        tick();
        present(C_SW, 5'd2, 5'd8, 5'd0);
        checks++;
        if (Stall_D !== 1'b1) begin errors++; $display("FAIL store_use_stall: got %b expected 1", Stall_D); end
        tick();
        checks++;
        if (Valid_E !== 1'b0) begin errors++; $display("FAIL store_use_bubble: got %b expected 0", Valid_E); end
        tick();
        present(C_LW, 5'd1, 5'd8, 5'd0);
        tick();
        present(C_ADDI, 5'd2, 5'd8, 5'd0);
        checks++;
        if (Stall_F !== 1'b0) begin errors++; $display("FAIL addi_no_stall: got %b expected 0", Stall_F); end
        tick();
        checks++;
        if (Valid_E !== 1'b1 || dut_e !== m_e) begin errors++; $display("FAIL addi_capture: got %h expected %h", dut_e, m_e); end
    endtask

    task automatic test_zero_reg();
        present(C_LW, 5'd4, 5'd0, 5'd0);
        tick();
        present(C_ADD, 5'd0, 5'd0, 5'd5);
        checks++;
        if (Stall_D !== 1'b0) begin errors++; $display("FAIL zero_reg_stall: got %b expected 0", Stall_D); end
        tick();
        checks++;
        if (Valid_E !== 1'b1 || Rd_E !== 5'd5 || dut_e !== m_e) begin errors++; $display("FAIL zero_reg_capture: got %h expected %h", dut_e, m_e); end
    endtask

    task automatic test_flush();
        present(C_LW, 5'd1, 5'd8, 5'd0);
        tick();
        present(C_ADD, 5'd8, 5'd8, 5'd3);
        Flush_E = 1'b1;
        #1;
        checks++;
        if ({Stall_F, Stall_D} !== 2'b00) begin errors++; $display("FAIL flush_stall: got %b expected 00", {Stall_F, Stall_D}); end
        tick();
        checks++;
        if (dut_e !== '0) begin errors++; $display("FAIL flush_nop: got %h expected 0", dut_e); end
        present(C_ADD, 5'd6, 5'd7, 5'd3);
        tick();
        checks++;
        if (Valid_E !== 1'b1 || dut_e !== m_e) begin errors++; $display("FAIL flush_next: got %h expected %h", dut_e, m_e); end
    endtask

    task automatic test_hold();
        logic [153:0] snap;
        present(C_LW, 5'd2, 5'd8, 5'd0);
        tick();
        snap = dut_e;
        for (int i = 0; i < 3; i++) begin
            present(C_ADD, 5'd8, 5'($urandom), 5'($urandom));
            Hold_E = 1'b1;
            #1;
            checks++;
            if (Stall_D !== 1'b0) begin errors++; $display("FAIL hold_stall: got %b expected 0", Stall_D); end
            tick();
            checks++;
            if (dut_e !== snap || dut_e !== m_e) begin errors++; $display("FAIL hold_keep: got %h expected %h", dut_e, snap); end
        end
    endtask

    task automatic test_reset_mid_stall();
        present(C_LW, 5'd1, 5'd9, 5'd0);
        tick();
        present(C_ADD, 5'd9, 5'd2, 5'd3);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        #1;
        checks++;
        if (Valid_E !== 1'b0 || {Stall_F, Stall_D} !== 2'b00) begin
            errors++; $display("FAIL reset_mid_stall: got valid %b stall %b expected 0 00", Valid_E, {Stall_F, Stall_D});
        end
    endtask

`ifdef ID_EX_BUBBLE_COUNT_EN
    task automatic test_bubble_count();
        Rst = 1'b1;
        tick();
        for (int n = 0; n < 2; n++) begin
            present(C_LW, 5'd3, 5'd8, 5'd0);
            tick();
            present(C_ADD, 5'd8, 5'd9, 5'd10);
            tick();
            tick();
        end
        checks++;
        if (Bubble_Count !== 32'd2) begin errors++; $display("FAIL bubble_count: got %0d expected 2", Bubble_Count); end
    endtask
`endif

    task automatic test_random();
        bit keep;
        for (int i = 0; i < 400; i++) begin
            keep = exp_stall();
            if (!keep)
                present(ctrl_t'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom));
            Rst     = ($urandom_range(0, 49) == 0);
            Flush_E = ($urandom_range(0, 9) == 0);
            Hold_E  = ($urandom_range(0, 7) == 0);
            #1;
            checks++;
            if ({Stall_F, Stall_D} !== {2{exp_stall()}}) begin
                errors++; $display("FAIL random_stall[%0d]: got %b expected %b", i, {Stall_F, Stall_D}, {2{exp_stall()}});
            end
            tick();
            checks++;
            if (dut_e !== m_e) begin errors++; $display("FAIL random_e[%0d]: got %h expected %h", i, dut_e, m_e); end
`ifdef ID_EX_BUBBLE_COUNT_EN
            checks++;
            if (Bubble_Count !== m_bubbles) begin errors++; $display("FAIL random_count[%0d]: got %0d expected %0d", i, Bubble_Count, m_bubbles); end
`endif
        end
    endtask

    initial begin
        m_e = '0;
        m_bubbles = 0;
        present(CTRL_NOP, 5'd0, 5'd0, 5'd0);
        test_reset();
        test_load_use();
        test_store_and_addi();
        test_zero_reg();
        test_flush();
        test_hold();
        test_reset_mid_stall();
`ifdef ID_EX_BUBBLE_COUNT_EN
        test_bubble_count();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
